// File: rtl/ar_id_allocator.sv
// Tags ID-less read requests with round-robin 4-bit ARIDs, caps the number of
// outstanding IDs, and passes in-order R data back while flagging misordered returns.
module ar_id_allocator #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] u_araddr_i,
  input  logic                  u_arvalid_i,
  output logic                  u_arready_o,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic [3:0]            m_arid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [3:0]            m_rid_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [DATA_WIDTH-1:0] u_rdata_o,
  output logic                  u_rvalid_o,
  input  logic                  u_rready_i,
  output logic [4:0]            outstanding_o,
  output logic                  order_err_o
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

  logic                  r_arvalid;
  logic [3:0]            r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [3:0]            r_alloc_ptr;
  logic [3:0]            r_release_ptr;
  logic [4:0]            r_count;
  logic                  r_err;

  logic                  w_not_full;
  logic                  w_arready;
  logic                  w_alloc;
  logic                  w_release;
  logic [4:0]            w_count_next;

  // rst_n gating keeps the requester from seeing ready while the block is held in reset
  assign w_not_full = (r_count < MAX_CNT);
  assign w_arready  = rst_n && (!r_arvalid || m_arready_i) && w_not_full;
  assign w_alloc    = u_arvalid_i && w_arready;
  assign w_release  = m_rvalid_i && u_rready_i;

  always_comb begin
    w_count_next = r_count;
    if (w_alloc && !w_release) begin
      w_count_next = r_count + 5'd1;
    end else if (w_release && !w_alloc) begin
      if (r_count != 5'd0) w_count_next = r_count - 5'd1;
    end else if (w_alloc && w_release && r_count == 5'd0) begin
      // a spurious release cannot cancel a genuine allocation
      w_count_next = 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arvalid     <= 1'b0;
      r_arid        <= 4'd0;
      r_araddr      <= '0;
      r_alloc_ptr   <= 4'd0;
      r_release_ptr <= 4'd0;
      r_count       <= 5'd0;
      r_err         <= 1'b0;
    end else begin
      if (w_alloc) begin
        r_arvalid   <= 1'b1;
        r_arid      <= r_alloc_ptr;
        r_araddr    <= u_araddr_i;
        r_alloc_ptr <= r_alloc_ptr + 4'd1;
      end else if (m_arready_i) begin
        r_arvalid <= 1'b0;
      end
      if (w_release) begin
        r_release_ptr <= r_release_ptr + 4'd1;
        if (r_count == 5'd0 || m_rid_i != r_release_ptr) r_err <= 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  assign u_arready_o   = w_arready;
  assign m_arvalid_o   = r_arvalid;
  assign m_arid_o      = r_arid;
  assign m_araddr_o    = r_araddr;
  assign outstanding_o = r_count;
  assign order_err_o   = r_err;

  assign u_rdata_o  = m_rdata_i;
  assign u_rvalid_o = m_rvalid_i;
  assign m_rready_o = u_rready_i;

endmodule

// File: tb/tb_ar_id_allocator.sv
// Directed plus randomized bench for ar_id_allocator against a queue-free
// behavioural model of ID issue, outstanding count and order checking.
module tb_ar_id_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] u_araddr_i;
  logic       u_arvalid_i;
  logic       u_arready_o;
  logic [7:0] m_araddr_o;
  logic [3:0] m_arid_o;
  logic       m_arvalid_o;
  logic       m_arready_i;
  logic [7:0] m_rdata_i;
  logic [3:0] m_rid_i;
  logic       m_rvalid_i;
  logic       m_rready_o;
  logic [7:0] u_rdata_o;
  logic       u_rvalid_o;
  logic       u_rready_i;
  logic [4:0] outstanding_o;
  logic       order_err_o;

  ar_id_allocator #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_araddr_i(u_araddr_i), .u_arvalid_i(u_arvalid_i), .u_arready_o(u_arready_o),
    .m_araddr_o(m_araddr_o), .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .u_rdata_o(u_rdata_o),
    .u_rvalid_o(u_rvalid_o), .u_rready_i(u_rready_i),
    .outstanding_o(outstanding_o), .order_err_o(order_err_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int  mdl_cnt;
  int  mdl_next_id;
  int  mdl_rel_id;
  bit  mdl_err;
  bit  mdl_mv;
  int  mdl_mid;
  int  mdl_maddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    mdl_cnt = 0; mdl_next_id = 0; mdl_rel_id = 0; mdl_err = 0;
    mdl_mv = 0; mdl_mid = 0; mdl_maddr = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_mvalid"}, m_arvalid_o, mdl_mv);
    chk({tag, "_mid"}, m_arid_o, mdl_mid);
    chk({tag, "_maddr"}, m_araddr_o, mdl_maddr);
    chk({tag, "_cnt"}, outstanding_o, mdl_cnt);
    chk({tag, "_err"}, order_err_o, mdl_err);
  endtask

  // One clock cycle; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input string tag, input bit arv, input int addr, input bit arr,
                     input bit rv, input int rid, input bit rr);
    bit exp_rdy, acc, rel;
    u_arvalid_i = arv; u_araddr_i = 8'(addr); m_arready_i = arr;
    m_rvalid_i = rv; m_rid_i = 4'(rid); u_rready_i = rr;
    m_rdata_i = 8'($urandom_range(0, 255));
    #1;
    exp_rdy = (!mdl_mv || arr) && (mdl_cnt < 16);
    chk({tag, "_arready"}, u_arready_o, exp_rdy);
    chk({tag, "_rdata"}, u_rdata_o, m_rdata_i);
    chk({tag, "_rvalid"}, u_rvalid_o, rv);
    chk({tag, "_rready"}, m_rready_o, rr);
    acc = arv && exp_rdy;
    rel = rv && rr;
    @(posedge clk); #1;
    if (acc) begin
      mdl_mv = 1; mdl_mid = mdl_next_id; mdl_maddr = addr & 8'hFF;
      mdl_next_id = (mdl_next_id + 1) % 16;
    end else if (arr) mdl_mv = 0;
    if (rel) begin
      if (mdl_cnt == 0 || rid != mdl_rel_id) mdl_err = 1;
      mdl_rel_id = (mdl_rel_id + 1) % 16;
    end
    mdl_cnt = mdl_cnt + (acc ? 1 : 0) - ((rel && mdl_cnt > 0) ? 1 : 0);
    check_state(tag);
    $display("%0t %s arv=%0b arr=%0b rv=%0b rid=%0d -> id=%0d cnt=%0d err=%0b",
             $time, tag, arv, arr, rv, rid, m_arid_o, outstanding_o, order_err_o);
  endtask

  // Assert reset asynchronously mid-cycle with inputs idle, check before the next edge.
  task automatic async_reset(input string tag);
    u_arvalid_i = 0; m_rvalid_i = 0; u_rready_i = 0; m_arready_i = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk({tag, "_rst_mvalid"}, m_arvalid_o, 1'b0);
    chk({tag, "_rst_cnt"}, outstanding_o, 5'd0);
    chk({tag, "_rst_err"}, order_err_o, 1'b0);
    chk({tag, "_rst_arready"}, u_arready_o, 1'b0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check_state({tag, "_post"});
  endtask

  initial begin
    rst_n = 0; u_arvalid_i = 0; u_araddr_i = 0; m_arready_i = 0;
    m_rvalid_i = 0; m_rid_i = 0; u_rready_i = 0; m_rdata_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_arready", u_arready_o, 1'b0);
    check_state("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // 1: three back-to-back requests
    for (int i = 0; i < 3; i++) begin
      cyc("t1", 1, 'h10 + i, 1, 0, 0, 0);
      chk("t1_id_seq", m_arid_o, 4'(i));
    end
    cyc("t1_idle", 0, 0, 1, 0, 0, 0);
    chk("t1_out3", outstanding_o, 5'd3);

    // 2: backpressure holds the register and stalls a second request
    cyc("t2_load", 1, 'h20, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t2_stall", 1, 'h21, 0, 0, 0, 0);
    chk("t2_hold_id", m_arid_o, 4'd3);
    chk("t2_hold_addr", m_araddr_o, 8'h20);
    cyc("t2_go", 1, 'h21, 1, 0, 0, 0);
    chk("t2_go_id", m_arid_o, 4'd4);
    cyc("t2_idle", 0, 0, 1, 0, 0, 0);

    // 4: simultaneous accept and return at 5 outstanding
    cyc("t4", 1, 'h30, 1, 1, 0, 1);
    chk("t4_cnt5", outstanding_o, 5'd5);
    for (int i = 1; i <= 5; i++) cyc("t4_drain", 0, 0, 1, 1, i, 1);
    chk("t4_empty", outstanding_o, 5'd0);
    // spurious release with nothing outstanding
    cyc("t4_spur", 0, 0, 1, 1, 6, 1);

    // 3: fill to 16 after a fresh reset, then wrap
    async_reset("t3");
    for (int i = 0; i < 16; i++) cyc("t3_fill", 1, 'h40 + i, 1, 0, 0, 0);
    cyc("t3_full", 1, 'h55, 1, 1, 0, 1);
    cyc("t3_wrap", 1, 'h56, 1, 0, 0, 0);
    chk("t3_wrap_id", m_arid_o, 4'd0);

    // 5: out-of-order return is sticky
    cyc("t5_ok", 0, 0, 1, 1, 1, 1);
    cyc("t5_bad", 0, 0, 1, 1, 3, 1);
    chk("t5_err_set", order_err_o, 1'b1);
    cyc("t5_later", 0, 0, 1, 1, 3, 1);
    chk("t5_err_sticky", order_err_o, 1'b1);

    // randomized traffic
    async_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      int rid;
      bit rv;
      rid = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : mdl_rel_id;
      rv = (mdl_cnt > 0) && ($urandom_range(0, 2) != 0);
      cyc("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          1'($urandom_range(0, 3) != 0), rv, rid, 1'($urandom_range(0, 1)));
    end

    // 6: async reset mid-burst
    async_reset("t6a");
    for (int i = 0; i < 4; i++) cyc("t6_burst", 1, 'h60 + i, 1, 0, 0, 0);
    chk("t6_pre_mvalid", m_arvalid_o, 1'b1);
    chk("t6_pre_cnt", outstanding_o, 5'd4);
    async_reset("t6");
    cyc("t6_first", 1, 'h70, 1, 0, 0, 0);
    chk("t6_first_id", m_arid_o, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
